// File: rtl/module_keypad_encoder.sv
// 4x4 matrix keypad scanner with debounce and key encoding.
// Scans one column at a time, debounces press and release, strobes valid_o.
module module_keypad_encoder #(
   parameter int SCAN_CYCLES     = 10000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] key_o,
   output logic       valid_o,
   output logic       held_o
);

   localparam int SW = $clog2(SCAN_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_PRESSED,
      S_RELEASE
   } state_t;

   state_t        state_q;
   logic [3:0]    sync1_q;
   logic [3:0]    row_q;
   logic [SW-1:0] dwell_q;
   logic [DW-1:0] deb_q;
   logic [1:0]    col_idx_q;
   logic [3:0]    col_q;
   logic [3:0]    pat_q;
   logic [3:0]    key_q;
   logic          valid_q;
   logic          held_q;

   logic [1:0]    col_nxt_d;
   logic [3:0]    col_oh_d;
   logic [1:0]    row_sel_d;
   logic [3:0]    code_d;

   assign col_o   = col_q;
   assign key_o   = key_q;
   assign valid_o = valid_q;
   assign held_o  = held_q;

   // Next column index and its active-low drive pattern.
   always_comb begin
      col_nxt_d = col_idx_q + 2'd1;
      col_oh_d  = ~(4'b0001 << col_nxt_d);
   end

   // Lowest-index low row of the captured pattern wins.
   always_comb begin
      if (!pat_q[0])      row_sel_d = 2'd0;
      else if (!pat_q[1]) row_sel_d = 2'd1;
      else if (!pat_q[2]) row_sel_d = 2'd2;
      else                row_sel_d = 2'd3;
   end

   // Key map lookup from (row, column).
   always_comb begin
      case ({row_sel_d, col_idx_q})
         4'b00_00: code_d = 4'h1;
         4'b00_01: code_d = 4'h2;
         4'b00_10: code_d = 4'h3;
         4'b00_11: code_d = 4'hA;
         4'b01_00: code_d = 4'h4;
         4'b01_01: code_d = 4'h5;
         4'b01_10: code_d = 4'h6;
         4'b01_11: code_d = 4'hB;
         4'b10_00: code_d = 4'h7;
         4'b10_01: code_d = 4'h8;
         4'b10_10: code_d = 4'h9;
         4'b10_11: code_d = 4'hC;
         4'b11_00: code_d = 4'hE;
         4'b11_01: code_d = 4'h0;
         4'b11_10: code_d = 4'hF;
         default:  code_d = 4'hD;
      endcase
   end

   // Two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 4'hF;
         row_q   <= 4'hF;
      end else begin
         sync1_q <= row_i;
         row_q   <= sync1_q;
      end
   end

   // Scan / debounce / press / release controller with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_SCAN;
         dwell_q   <= '0;
         deb_q     <= '0;
         col_idx_q <= 2'd0;
         col_q     <= 4'b1110;
         pat_q     <= 4'hF;
         key_q     <= 4'h0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_SCAN: begin
               if (dwell_q == SCAN_LAST) begin
                  dwell_q <= '0;
                  if (row_q == 4'hF) begin
                     col_idx_q <= col_nxt_d;
                     col_q     <= col_oh_d;
                  end else begin
                     pat_q   <= row_q;
                     deb_q   <= '0;
                     state_q <= S_DEBOUNCE;
                  end
               end else begin
                  dwell_q <= dwell_q + SW'(1);
               end
            end
            S_DEBOUNCE: begin
               if (row_q == pat_q) begin
                  if (deb_q == DEB_LAST) begin
                     state_q <= S_PRESSED;
                     key_q   <= code_d;
                     valid_q <= 1'b1;
                     held_q  <= 1'b1;
                  end else begin
                     deb_q <= deb_q + DW'(1);
                  end
               end else begin
                  state_q   <= S_SCAN;
                  dwell_q   <= '0;
                  col_idx_q <= col_nxt_d;
                  col_q     <= col_oh_d;
               end
            end
            S_PRESSED: begin
               state_q <= S_RELEASE;
               deb_q   <= '0;
            end
            S_RELEASE: begin
               if (row_q == 4'hF) begin
                  if (deb_q == DEB_LAST) begin
                     state_q   <= S_SCAN;
                     held_q    <= 1'b0;
                     dwell_q   <= '0;
                     col_idx_q <= col_nxt_d;
                     col_q     <= col_oh_d;
                  end else begin
                     deb_q <= deb_q + DW'(1);
                  end
               end else begin
                  deb_q <= '0;
               end
            end
            default: state_q <= S_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_module_keypad_encoder.sv
// Bench for module_keypad_encoder with a physical keypad model.
// Randomized key choice and hold times; directed scenarios in one sequence.
module tb_module_keypad_encoder;

   localparam int SCAN = 4;
   localparam int DEB  = 8;

   logic       clk;
   logic       rst;
   logic [3:0] row_i;
   logic [3:0] col_o;
   logic [3:0] key_o;
   logic       valid_o;
   logic       held_o;

   int vectors     = 0;
   int miscompares = 0;

   logic pressed [4][4];

   logic [3:0] kmap [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   module_keypad_encoder #(
      .SCAN_CYCLES(SCAN),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .row_i(row_i),
      .col_o(col_o),
      .key_o(key_o),
      .valid_o(valid_o),
      .held_o(held_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Physical keypad: a pressed switch shorts its row to its driven-low column.
   always_comb begin
      row_i = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && !col_o[c]) row_i[r] = 1'b0;
   end

   function automatic logic [3:0] col_mask(input int c);
      logic [3:0] m;
      m = 4'hF;
      m[c % 4] = 1'b0;
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_keys();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            pressed[r][c] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_until_valid(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (valid_o) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int k, output int p);
      p = 0;
      for (int i = 0; i < k; i++) begin
         tick();
         if (valid_o) p++;
      end
   endtask

   // Drop every key; held_o must stay up through sync plus debounce window.
   task automatic release_and_check(input string tag, input int next_col);
      clear_keys();
      repeat (DEB + 1) tick();
      check({tag, "_held_before_drop"}, held_o, 1);
      tick();
      check({tag, "_held_dropped"}, held_o, 0);
      check({tag, "_next_col"}, col_o, col_mask(next_col));
   endtask

   initial begin
      int n;
      int p;
      int r;
      int c;
      int hold;
      int seen;
      logic [3:0] newcol;
      int kr [6];
      int kc [6];

      clear_keys();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_col", col_o, 4'b1110);
      check("rst_key", key_o, 4'h0);
      check("rst_valid", valid_o, 0);
      check("rst_held", held_o, 0);
      rst = 1'b0;

      // Idle scan: column advances every SCAN cycles, no strobes.
      for (int i = 0; i < 8 * SCAN; i++) begin
         check("idle_col", col_o, col_mask(i / SCAN));
         check("idle_valid", valid_o, 0);
         tick();
      end
      check("idle_key", key_o, 4'h0);

      // Single key presses from reset: key "5" then random keys.
      kr[0] = 1;
      kc[0] = 1;
      for (int k = 1; k < 6; k++) begin
         kr[k] = $urandom_range(0, 3);
         kc[k] = $urandom_range(0, 3);
      end
      for (int k = 0; k < 6; k++) begin
         r = kr[k];
         c = kc[k];
         do_reset();
         pressed[r][c] = 1'b1;
         run_until_valid(60, n);
         check("press_latency", n, (c + 1) * SCAN + DEB);
         check("press_key", key_o, kmap[r][c]);
         check("press_held", held_o, 1);
         hold = $urandom_range(5, 30);
         count_pulses(hold, p);
         check("press_single_pulse", p, 0);
         check("press_still_held", held_o, 1);
         release_and_check("press", c + 1);
      end

      // Bouncing "#": no strobe while bouncing, one after it settles.
      p = 0;
      for (int i = 0; i < 30; i++) begin
         pressed[3][2] = ((i / 3) % 2) == 0;
         tick();
         if (valid_o) p++;
      end
      check("bounce_no_pulse", p, 0);
      pressed[3][2] = 1'b1;
      run_until_valid(60, n);
      check("bounce_seen", n > 0, 1);
      check("bounce_key", key_o, 4'hF);
      count_pulses(20, p);
      check("bounce_single_pulse", p, 0);
      release_and_check("bounce", 3);

      // Rows 0 and 2 on col3, then "7" while held.
      pressed[0][3] = 1'b1;
      pressed[2][3] = 1'b1;
      run_until_valid(60, n);
      check("multi_seen", n > 0, 1);
      check("multi_key", key_o, 4'hA);
      pressed[2][0] = 1'b1;
      count_pulses(30, p);
      check("multi_no_second", p, 0);
      check("multi_held", held_o, 1);
      release_and_check("multi", 0);

      // Reset during RELEASE with "D" held.
      pressed[3][3] = 1'b1;
      run_until_valid(60, n);
      check("rstmid_seen", n > 0, 1);
      check("rstmid_key", key_o, 4'hD);
      repeat (3) tick();
      check("rstmid_in_release", held_o, 1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_col", col_o, 4'b1110);
      check("rstmid_key0", key_o, 4'h0);
      check("rstmid_valid", valid_o, 0);
      check("rstmid_held", held_o, 0);
      @(negedge clk);
      rst = 1'b0;
      run_until_valid(60, n);
      check("rstmid_latency", n, 4 * SCAN + DEB);
      check("rstmid_key_again", key_o, 4'hD);
      release_and_check("rstmid", 0);

      // Short press of "0": rejected, scan moves on to col2.
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (col_o == 4'b1101) begin
            seen = 1;
            break;
         end
      end
      check("short_col1_reached", seen, 1);
      p = 0;
      pressed[3][1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (valid_o) p++;
      end
      pressed[3][1] = 1'b0;
      seen = 0;
      newcol = 4'b1101;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (valid_o) p++;
         if (seen == 0 && col_o != 4'b1101) begin
            seen = 1;
            newcol = col_o;
         end
      end
      check("short_no_pulse", p, 0);
      check("short_next_col", newcol, col_mask(2));
      check("short_key_kept", key_o, kmap[3][3]);
      check("short_not_held", held_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
